// File: rtl/or5_bist_checker_if.sv
// ---------------------------------------------------------------------------
// or5_bist_checker_if
// Bus between the OR5 BIST checker and its environment.
//   start             : one-cycle run request (into the checker)
//   dut_out[4:0]      : response of the 5-bit OR unit under test (into checker)
//   op_a/op_b[4:0]    : operands driven to the unit under test
//   busy/done/pass    : run status
//   err_count[ERR_W]  : saturating count of mismatching vectors
//   fail_a/b/out[4:0] : first failing vector and its response
// Modports: master = environment/bench side, slave = checker side.
// ---------------------------------------------------------------------------
interface or5_bist_checker_if #(
   parameter int ERR_W = 8
);
   logic             start;
   logic [4:0]       dut_out;
   logic [4:0]       op_a;
   logic [4:0]       op_b;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic [4:0]       fail_a;
   logic [4:0]       fail_b;
   logic [4:0]       fail_out;

   modport master (
      output start, dut_out,
      input  op_a, op_b, busy, done, pass, err_count, fail_a, fail_b, fail_out
   );

   modport slave (
      input  start, dut_out,
      output op_a, op_b, busy, done, pass, err_count, fail_a, fail_b, fail_out
   );
endinterface

// File: rtl/or5_bist_checker.sv
// ---------------------------------------------------------------------------
// or5_bist_checker
// Exhaustive built-in self test for a combinational 5-bit OR unit. A run
// walks all 1024 (A, B) operand pairs; each pair gets an APPLY cycle for the
// unit to settle and a CHECK cycle where its response is compared against
// A | B. Mismatches are counted in a saturating counter.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : or5_bist_checker_if.slave (start, dut_out in; op_a, op_b, busy,
//           done, pass, err_count, fail_a, fail_b, fail_out out)
//
// Optional feature: define OR5_BIST_FIRST_FAIL_EN to capture the first
// failing vector and response into fail_a/fail_b/fail_out. Without it those
// outputs are tied to zero.
// ---------------------------------------------------------------------------
module or5_bist_checker #(
   parameter int ERR_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   or5_bist_checker_if.slave    bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] APPLY = 2'd1;
   localparam logic [1:0] CHECK = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [ERR_W-1:0] ERR_MAX  = '1;
   localparam logic [9:0]       LAST_VEC = 10'd1023;

   logic [1:0]       state;
   logic [9:0]       vec_cnt;
   logic [ERR_W-1:0] err_count;
   logic             run_start;
   logic             mismatch;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (v == ERR_MAX) ? v : v + 1'b1;
   endfunction

   // start is only honoured when no run is in progress
   assign run_start = bus.start && ((state == IDLE) || (state == DONE));
   assign mismatch  = (state == CHECK) &&
                      (bus.dut_out != (vec_cnt[9:5] | vec_cnt[4:0]));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         vec_cnt   <= '0;
         err_count <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state     <= APPLY;
                  vec_cnt   <= '0;
                  err_count <= '0;
               end
            end
            APPLY: state <= CHECK;
            CHECK: begin
               // the final vector is still counted on the edge into DONE
               if (mismatch) err_count <= sat_inc(err_count);
               if (vec_cnt != LAST_VEC) begin
                  vec_cnt <= vec_cnt + 10'd1;
                  state   <= APPLY;
               end else begin
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Operands come straight from the vector register, so they are stable
   // across the APPLY/CHECK pair.
   assign bus.op_a      = vec_cnt[9:5];
   assign bus.op_b      = vec_cnt[4:0];
   assign bus.busy      = (state == APPLY) || (state == CHECK);
   assign bus.done      = (state == DONE);
   assign bus.pass      = (state == DONE) && (err_count == '0);
   assign bus.err_count = err_count;

`ifdef OR5_BIST_FIRST_FAIL_EN
   logic [4:0] fail_a;
   logic [4:0] fail_b;
   logic [4:0] fail_out;

   // err_count is zero until the first mismatch of the run has been counted,
   // which marks the first failure without a separate flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fail_a   <= '0;
         fail_b   <= '0;
         fail_out <= '0;
      end else if (run_start) begin
         fail_a   <= '0;
         fail_b   <= '0;
         fail_out <= '0;
      end else if (mismatch && (err_count == '0)) begin
         fail_a   <= vec_cnt[9:5];
         fail_b   <= vec_cnt[4:0];
         fail_out <= bus.dut_out;
      end
   end

   assign bus.fail_a   = fail_a;
   assign bus.fail_b   = fail_b;
   assign bus.fail_out = fail_out;
`else
   logic unused_run_start;
   assign unused_run_start = run_start;
   assign bus.fail_a   = '0;
   assign bus.fail_b   = '0;
   assign bus.fail_out = '0;
`endif

endmodule

// File: tb/tb_or5_bist_checker.sv
// ---------------------------------------------------------------------------
// tb_or5_bist_checker
// Directed bench for or5_bist_checker. A behavioural model of the OR unit
// under test drives dut_out; model_mode selects correct OR, a single-vector
// fault at (A=11111, B=00111), or output stuck at zero.
// ---------------------------------------------------------------------------
module tb_or5_bist_checker;

`ifdef OR5_BIST_FIRST_FAIL_EN
   localparam bit FF_EN = 1'b1;
`else
   localparam bit FF_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   model_mode;
   int   tests = 0;
   int   fails = 0;
   int   k;
   int   busy_low;

   or5_bist_checker_if #(.ERR_W(8)) bi ();

   or5_bist_checker #(.ERR_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bi.slave)
   );

   always #5 clk = ~clk;

   // model of the 5-bit OR unit under test
   assign bi.dut_out =
      (model_mode == 0) ? (bi.op_a | bi.op_b) :
      (model_mode == 1) ? (((bi.op_a == 5'b11111) && (bi.op_b == 5'b00111)) ?
                           ((bi.op_a | bi.op_b) ^ 5'b00001) : (bi.op_a | bi.op_b)) :
                          5'b00000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"}, 32'(bi.busy), 0);
      check({tag, "_done"}, 32'(bi.done), 0);
      check({tag, "_pass"}, 32'(bi.pass), 0);
      check({tag, "_err"}, 32'(bi.err_count), 0);
      check({tag, "_opa"}, 32'(bi.op_a), 0);
      check({tag, "_opb"}, 32'(bi.op_b), 0);
      check({tag, "_fa"}, 32'(bi.fail_a), 0);
      check({tag, "_fb"}, 32'(bi.fail_b), 0);
      check({tag, "_fo"}, 32'(bi.fail_out), 0);
   endtask

   // start high for exactly one rising edge; returns at the negedge after it
   task automatic start_run();
      @(negedge clk) bi.start = 1'b1;
      @(negedge clk) bi.start = 1'b0;
   endtask

   // k counts rising edges since start was sampled; optionally pulses start
   // again at edge count pulse_at
   task automatic wait_done(input int pulse_at, output int kk, output int low);
      kk  = 1;
      low = 0;
      while (!bi.done && kk < 4000) begin
         @(negedge clk);
         kk++;
         bi.start = (kk == pulse_at);
         if (!bi.busy && !bi.done) low++;
      end
      bi.start = 1'b0;
   endtask

   initial begin
      model_mode = 0;
      bi.start   = 1'b0;
      reset      = 1'b1;
      repeat (2) @(negedge clk);
      check_zero_outputs("reset");
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_busy", 32'(bi.busy), 0);
      check("idle_done", 32'(bi.done), 0);

      // passing run
      start_run();
      check("p1_busy", 32'(bi.busy), 1);
      check("p1_opa0", 32'(bi.op_a), 0);
      check("p1_opb0", 32'(bi.op_b), 0);
      @(negedge clk);
      @(negedge clk);
      check("p1_opb1", 32'(bi.op_b), 1);
      check("p1_opa1", 32'(bi.op_a), 0);
      wait_done(-1, k, busy_low);
      k = k + 2;
      check("p1_len", 32'(k), 2049);
      check("p1_busylow", 32'(busy_low), 0);
      check("p1_done", 32'(bi.done), 1);
      check("p1_pass", 32'(bi.pass), 1);
      check("p1_err", 32'(bi.err_count), 0);
      check("p1_busy_end", 32'(bi.busy), 0);
      check("p1_opa_end", 32'(bi.op_a), 31);
      check("p1_opb_end", 32'(bi.op_b), 31);
      repeat (10) @(negedge clk);
      check("p1_done_held", 32'(bi.done), 1);

      // single faulty vector
      model_mode = 1;
      start_run();
      check("f1_done_drop", 32'(bi.done), 0);
      wait_done(-1, k, busy_low);
      check("f1_len", 32'(k), 2049);
      check("f1_err", 32'(bi.err_count), 1);
      check("f1_pass", 32'(bi.pass), 0);
      check("f1_fa", 32'(bi.fail_a), FF_EN ? 32'h1f : 0);
      check("f1_fb", 32'(bi.fail_b), FF_EN ? 32'h07 : 0);
      check("f1_fo", 32'(bi.fail_out), FF_EN ? 32'h1e : 0);

      // stuck-at-zero output: 1023 mismatches saturate at 255
      model_mode = 2;
      start_run();
      wait_done(-1, k, busy_low);
      check("s0_len", 32'(k), 2049);
      check("s0_err", 32'(bi.err_count), 255);
      check("s0_pass", 32'(bi.pass), 0);
      check("s0_fa", 32'(bi.fail_a), 0);
      check("s0_fb", 32'(bi.fail_b), FF_EN ? 32'h01 : 0);
      check("s0_fo", 32'(bi.fail_out), 0);

      // restart from a failing DONE with a correct model
      model_mode = 0;
      start_run();
      check("rs_err_clr", 32'(bi.err_count), 0);
      check("rs_done", 32'(bi.done), 0);
      check("rs_busy", 32'(bi.busy), 1);
      check("rs_fb_clr", 32'(bi.fail_b), 0);
      wait_done(-1, k, busy_low);
      check("rs_len", 32'(k), 2049);
      check("rs_pass", 32'(bi.pass), 1);

      // start pulse while busy is ignored
      start_run();
      wait_done(100, k, busy_low);
      check("ig_len", 32'(k), 2049);
      check("ig_busylow", 32'(busy_low), 0);
      check("ig_pass", 32'(bi.pass), 1);

      // reset in the middle of a failing run
      model_mode = 2;
      start_run();
      repeat (499) @(negedge clk);
      check("mr_err_nz", 32'(bi.err_count != 0), 1);
      reset = 1'b1;
      #1;
      check_zero_outputs("mr");
      @(negedge clk) reset = 1'b0;
      repeat (10) @(negedge clk);
      check("mr_idle_busy", 32'(bi.busy), 0);
      check("mr_idle_done", 32'(bi.done), 0);
      model_mode = 0;
      start_run();
      wait_done(-1, k, busy_low);
      check("mr_len", 32'(k), 2049);
      check("mr_pass", 32'(bi.pass), 1);
      check("mr_err", 32'(bi.err_count), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/or5_bist_checker.md
OR5_BIST_CHECKER -- requirements
Module: or5_bist_checker

Interface
REQ-001 Parameter ERR_W, default 8, width of the error counter.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a test run.
REQ-005 dut_out  input  5  response of the 5-bit OR unit under test.
REQ-006 op_a  output  5  operand A driven to the unit under test.
REQ-007 op_b  output  5  operand B driven to the unit under test.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  high once a run has completed; held until the next start.
REQ-010 pass  output  1  high with done when zero mismatches were recorded.
REQ-011 err_count  output  ERR_W  number of mismatching vectors, saturating.
REQ-012 fail_a, fail_b, fail_out  output  5 each  first failing vector and its response (see Configuration).

Function
REQ-013 FSM states SHALL be IDLE, APPLY, CHECK and DONE.
REQ-014 Transitions SHALL be:
- IDLE -> APPLY on start.
- APPLY -> CHECK unconditionally.
- CHECK -> APPLY if vec_cnt != 1023, else CHECK -> DONE.
- DONE -> APPLY on start.
REQ-015 A 10-bit vector counter vec_cnt SHALL drive op_a = vec_cnt[9:5] and op_b = vec_cnt[4:0], registered.
REQ-016 vec_cnt SHALL clear to 0 on every entry to APPLY from IDLE or DONE.
REQ-017 vec_cnt SHALL increment on each CHECK -> APPLY transition, giving exhaustive coverage of all 1024 (A, B) pairs.
REQ-018 Operands SHALL be held stable through APPLY and CHECK, so the combinational unit under test gets one full settle cycle.
REQ-019 In CHECK, dut_out SHALL be compared against (op_a | op_b); a mismatch SHALL increment err_count at that clock edge.
REQ-020 err_count SHALL saturate at 2^ERR_W-1 and never wrap.
REQ-021 err_count SHALL clear to 0 together with vec_cnt when a new run begins.
REQ-022 busy SHALL be high exactly in APPLY and CHECK.
REQ-023 done SHALL be high exactly in DONE.
REQ-024 A run SHALL take 2048 cycles from the first APPLY to the entry into DONE.
REQ-025 pass SHALL be high only in DONE and only when err_count == 0.
REQ-026 start asserted while busy SHALL be ignored; the current run is not restarted.
REQ-027 start asserted in DONE SHALL begin a fresh run, clearing err_count and the capture registers, and drop done on the next cycle.
REQ-028 A mismatch on the final vector (1023) SHALL still be counted before done rises.

Reset
REQ-029 reset SHALL asynchronously force: state IDLE; vec_cnt 0; op_a and op_b 0; err_count 0; fail_a, fail_b and fail_out 0; busy, done and pass 0.
REQ-030 reset asserted mid-run SHALL abort the run; no partial done or pass is ever reported.
REQ-031 After reset deasserts, the block SHALL stay in IDLE until start.

Configuration
REQ-032 Macro OR5_BIST_FIRST_FAIL_EN defined: on the first mismatch of a run, fail_a, fail_b and fail_out SHALL capture op_a, op_b and dut_out.
REQ-033 With the macro defined, the captured values SHALL then hold until the next run start or reset; later mismatches SHALL not overwrite them.
REQ-034 Macro OR5_BIST_FIRST_FAIL_EN undefined: fail_a, fail_b and fail_out SHALL remain present but be tied to 0, and no capture logic is built.

Verification
REQ-035 Correct OR model on dut_out, start pulse: busy for 2048 cycles, then done=1, pass=1, err_count=0.
REQ-036 dut_out forced wrong only when op_a=5'b11111 and op_b=5'b00111:
- Required: err_count=1, pass=0.
- With the macro defined: fail_a=11111, fail_b=00111.
REQ-037 dut_out stuck at 5'b00000:
- Vectors where A|B differs from 0 number 1023, so err_count saturates at 255 (ERR_W=8) and pass=0.
- With the macro defined: fail_a=00000, fail_b=00001.
REQ-038 start pulsed at cycle 100 of a run: ignored, and done still rises 2048 cycles after the original start.
REQ-039 reset asserted at cycle 500 of a run:
- All outputs return to 0 immediately, with no done.
- A new start then produces a full 2048-cycle run.
REQ-040 start pulsed in DONE after a failing run: err_count clears, done drops the next cycle, and a passing model then yields pass=1.
